// File: rtl/uart_rx_config_loader_pkg.sv
// uart_rx_config_loader_pkg
// Shared constants and state types for the configuration-bus UART receiver.
// Holds the bus width, the command codes and the default bit divider. The
// transmitter side uses the same values.
// Optional feature macro: UART_RX_CFG_CHKSUM_EN (XOR checksum byte per frame).
package uart_rx_config_loader_pkg;

    localparam int busWIDTH    = 31;           // bus is busWIDTH+1 bits wide
    localparam int BUS_W       = busWIDTH + 1; // must be a multiple of 8
    localparam int NB          = BUS_W / 8;    // data bytes per frame
    localparam int CLK_DIV_DEF = 87;           // 10 MHz / 115200, rounded

    localparam logic [7:0] CMD_SET = 8'h53;    // 'S': set bus from frame
    localparam logic [7:0] CMD_DEF = 8'h44;    // 'D': restore busDefault

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        P_WAIT_CMD,
        P_DATA,
        P_CHK
    } parse_state_e;

endpackage

// File: rtl/uart_rx_only.sv
// uart_rx_only
// 8N1 receiver: 2-flop synchroniser plus a bit engine that samples at the bit
// centre. Its port set mirrors uart_tx_only so the two pair up in loopback.
// Ports:
//   clk10mhz  in   system clock
//   nRst      in   synchronous reset, active low
//   uRx       in   asynchronous serial line, idle high
//   rxData8   out  last good byte (valid while rxValid is high)
//   rxValid   out  one-cycle pulse, good stop bit
//   rxErr     out  one-cycle pulse, stop bit sampled low
module uart_rx_only
    import uart_rx_config_loader_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic       clk10mhz,
    input  logic       nRst,
    input  logic       uRx,
    output logic [7:0] rxData8,
    output logic       rxValid,
    output logic       rxErr
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);

    rx_state_e     st;
    logic          sync1, sync2, rx_prev;
    logic          fall, fall_q;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign fall = rx_prev & ~sync2;

    always_ff @(posedge clk10mhz) begin
        if (!nRst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
            fall_q  <= 1'b0;
            st      <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            rxData8 <= '0;
            rxValid <= 1'b0;
            rxErr   <= 1'b0;
        end else begin
            sync1   <= uRx;
            sync2   <= sync1;
            rx_prev <= sync2;
            // Remembered for one cycle so an edge landing on the STOP
            // decision cycle is still picked up by IDLE on the next cycle.
            fall_q  <= fall;
            rxValid <= 1'b0;
            rxErr   <= 1'b0;
            case (st)
                RX_IDLE: begin
                    cnt <= '0;
                    if (fall || fall_q) st <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // line back high at mid start bit: glitch, no error
                        st      <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shreg   <= {sync2, shreg[7:1]};   // LSB first
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) st <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        st  <= RX_IDLE;
                        if (sync2) begin
                            rxData8 <= shreg;
                            rxValid <= 1'b1;
                        end else begin
                            rxErr <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_config_loader.sv
// uart_rx_config_loader
// Receives command frames over the UART and drives the live configuration
// bus. Protocol: 'S' + NB data bytes (MSB byte first) sets busNow; 'D'
// restores busDefault. Other bytes outside a frame are ignored.
// Optional macro UART_RX_CFG_CHKSUM_EN: a frame carries one extra byte, the
// XOR of the data bytes; the frame commits only if it matches.
// Ports:
//   clk10mhz    in   system clock
//   nRst        in   synchronous reset, active low
//   uRx         in   asynchronous serial line, idle high
//   busDefault  in   value loaded at reset and by 'D'
//   busNow      out  live configuration value
//   cfgValid    out  one-cycle pulse when busNow is written
//   frameErr    out  one-cycle pulse on stop error, checksum error, timeout
module uart_rx_config_loader
    import uart_rx_config_loader_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int TIMEOUT = 20000
) (
    input  logic              clk10mhz,
    input  logic              nRst,
    input  logic              uRx,
    input  logic [busWIDTH:0] busDefault,
    output logic [busWIDTH:0] busNow,
    output logic              cfgValid,
    output logic              frameErr
);

    localparam int IW = $clog2(NB + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [7:0]   rx_byte;
    logic         rx_valid, rx_err;

    parse_state_e pst;
    logic [BUS_W-1:0] stage, stage_next;
    logic [IW-1:0] byte_idx;
    logic [TW-1:0] tmo;
`ifdef UART_RX_CFG_CHKSUM_EN
    logic [7:0]   acc;
`endif

    uart_rx_only #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk10mhz (clk10mhz),
        .nRst     (nRst),
        .uRx      (uRx),
        .rxData8  (rx_byte),
        .rxValid  (rx_valid),
        .rxErr    (rx_err)
    );

    // shift written so it also elaborates for a one-byte bus
    assign stage_next = (stage << 8) | BUS_W'(rx_byte);

    always_ff @(posedge clk10mhz) begin
        if (!nRst) begin
            busNow   <= busDefault;
            cfgValid <= 1'b0;
            frameErr <= 1'b0;
            pst      <= P_WAIT_CMD;
            stage    <= '0;
            byte_idx <= '0;
            tmo      <= '0;
`ifdef UART_RX_CFG_CHKSUM_EN
            acc      <= '0;
`endif
        end else begin
            cfgValid <= 1'b0;
            frameErr <= 1'b0;
            // The three branches are exclusive, so cfgValid and frameErr
            // can never be raised together.
            if (rx_err) begin
                frameErr <= 1'b1;
                pst      <= P_WAIT_CMD;
                tmo      <= '0;
            end else if (rx_valid) begin
                tmo <= '0;
                case (pst)
                    P_WAIT_CMD: begin
                        if (rx_byte == CMD_SET) begin
                            stage    <= '0;
                            byte_idx <= '0;
`ifdef UART_RX_CFG_CHKSUM_EN
                            acc      <= '0;
`endif
                            pst      <= P_DATA;
                        end else if (rx_byte == CMD_DEF) begin
                            busNow   <= busDefault;
                            cfgValid <= 1'b1;
                        end
                    end
                    P_DATA: begin
                        stage    <= stage_next;
                        byte_idx <= byte_idx + 1'b1;
`ifdef UART_RX_CFG_CHKSUM_EN
                        acc      <= acc ^ rx_byte;
                        if (byte_idx == IW'(NB - 1)) pst <= P_CHK;
`else
                        if (byte_idx == IW'(NB - 1)) begin
                            busNow   <= stage_next;
                            cfgValid <= 1'b1;
                            pst      <= P_WAIT_CMD;
                        end
`endif
                    end
`ifdef UART_RX_CFG_CHKSUM_EN
                    P_CHK: begin
                        if (rx_byte == acc) begin
                            busNow   <= stage;
                            cfgValid <= 1'b1;
                        end else begin
                            frameErr <= 1'b1;
                        end
                        pst <= P_WAIT_CMD;
                    end
`endif
                    default: pst <= P_WAIT_CMD;
                endcase
            end else if (pst != P_WAIT_CMD) begin
                // inter-byte silence inside a frame: drop the partial frame
                if (tmo == TW'(TIMEOUT - 1)) begin
                    frameErr <= 1'b1;
                    pst      <= P_WAIT_CMD;
                    tmo      <= '0;
                end else begin
                    tmo <= tmo + 1'b1;
                end
            end else begin
                tmo <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_config_loader.sv
`timescale 1ns/1ps
module tb_uart_rx_config_loader;

    localparam int BIT = 87;
`ifdef UART_RX_CFG_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk10mhz = 1'b0;
    logic        nRst     = 1'b0;
    logic        uRx      = 1'b1;
    logic [31:0] busDefault = 32'hA5A5A5A5;
    logic [31:0] busNow;
    logic        cfgValid, frameErr;

    int n_vec = 0;
    int n_err = 0;
    int cfg_cnt = 0, err_cnt = 0, both_cnt = 0;
    int cfg0, err0;
    logic [31:0] exp_bus;
    logic [7:0]  tx_q[$];

    uart_rx_config_loader dut (
        .clk10mhz   (clk10mhz),
        .nRst       (nRst),
        .uRx        (uRx),
        .busDefault (busDefault),
        .busNow     (busNow),
        .cfgValid   (cfgValid),
        .frameErr   (frameErr)
    );

    always #50 clk10mhz = ~clk10mhz;

    // pulse monitor, sampled away from the active edge; every high cycle counts
    always @(negedge clk10mhz) begin
        if (cfgValid === 1'b1) cfg_cnt++;
        if (frameErr === 1'b1) err_cnt++;
        if (cfgValid === 1'b1 && frameErr === 1'b1) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mark();
        cfg0 = cfg_cnt;
        err0 = err_cnt;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk10mhz);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        uRx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            uRx = b[i];
            idle(BIT);
        end
        uRx = stop_val;
        idle(BIT);
        uRx = 1'b1;
        idle(20);
    endtask

    task automatic send_q();
        foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
        idle(100);
    endtask

    task automatic pulses(input string tag, input int cfg_exp, input int err_exp);
        chk({tag, "_cfg"}, 32'(cfg_cnt - cfg0), 32'(cfg_exp));
        chk({tag, "_err"}, 32'(err_cnt - err0), 32'(err_exp));
    endtask

    initial begin
        // reset
        idle(5);
        chk("bus_in_reset", busNow, 32'hA5A5A5A5);
        nRst = 1'b1;
        mark();
        idle(500);
        chk("bus_after_reset", busNow, 32'hA5A5A5A5);
        pulses("reset_idle", 0, 0);

        // good frame, correct checksum (trailing byte ignored without checksum)
        mark();
        tx_q = '{8'h53, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        send_q();
        exp_bus = 32'h12345678;
        chk("frame_ok_bus", busNow, exp_bus);
        pulses("frame_ok", 1, 0);

        // same data, wrong checksum
        mark();
        tx_q = '{8'h53, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        send_q();
        chk("bad_chk_bus", busNow, exp_bus);
        pulses("bad_chk", CHK ? 0 : 1, CHK ? 1 : 0);

        // different data, wrong checksum (correct would be 0x44)
        mark();
        tx_q = '{8'h53, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        send_q();
        if (!CHK) exp_bus = 32'h11223344;
        chk("bad_chk2_bus", busNow, exp_bus);
        pulses("bad_chk2", CHK ? 0 : 1, CHK ? 1 : 0);

        // partial frame then silence beyond the timeout
        mark();
        tx_q = '{8'h53, 8'h12, 8'h34};
        send_q();
        pulses("partial_pre_timeout", 0, 0);
        idle(20500);
        chk("timeout_bus", busNow, exp_bus);
        pulses("timeout", 0, 1);

        // 'D' restores the default
        mark();
        tx_q = '{8'h44};
        send_q();
        chk("def_cmd_bus", busNow, 32'hA5A5A5A5);
        pulses("def_cmd", 1, 0);

        // stop bit forced low, then a normal frame
        mark();
        send_byte(8'h55, 1'b0);
        idle(200);
        chk("stop_err_bus", busNow, 32'hA5A5A5A5);
        pulses("stop_err", 0, 1);
        mark();
        tx_q = '{8'h53, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h30};
        send_q();
        chk("after_err_bus", busNow, 32'hCAFEBABE);
        pulses("after_err", 1, 0);

        // 40-cycle glitch: shorter than half a bit, rejected
        mark();
        uRx = 1'b0;
        idle(40);
        uRx = 1'b1;
        idle(300);
        chk("glitch_bus", busNow, 32'hCAFEBABE);
        pulses("glitch", 0, 0);

        // reset in the middle of a frame, then a full frame
        mark();
        tx_q = '{8'h53, 8'h12};
        send_q();
        nRst = 1'b0;
        idle(3);
        nRst = 1'b1;
        idle(50);
        chk("midreset_bus", busNow, 32'hA5A5A5A5);
        pulses("midreset", 0, 0);
        mark();
        tx_q = '{8'h53, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_q();
        chk("post_reset_bus", busNow, 32'h01020304);
        pulses("post_reset", 1, 0);

        chk("cfg_err_overlap", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
